// File: rtl/sirv_tl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sirv_tl_pkg
// Brief    : Shared TileLink-UL opcodes, fragmenter FSM encoding and the
//            size-to-fragment-count helper.
// Revision : 1.0
// ============================================================================
package sirv_tl_pkg;

    localparam logic [2:0] GET           = 3'd4;
    localparam logic [2:0] PUTFULL       = 3'd0;
    localparam logic [2:0] ACCESSACK     = 3'd0;
    localparam logic [2:0] ACCESSACKDATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } frag_state_e;

    // Number of single-byte fragments for a 2^size byte transfer
    function automatic logic [7:0] frag_count(input logic [2:0] size);
        return 8'd1 << size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sirv_tl_fragmenter_core_if.sv
`default_nettype none
// ============================================================================
// Module   : sirv_tl_fragmenter_core_if
// Brief    : Upstream A/D, downstream A/D and repeat control of the fragmenter.
// Revision : 1.0
// ============================================================================
interface sirv_tl_fragmenter_core_if #(
    parameter int ADDR_W = 30,
    parameter int SRC_W  = 2
);
    logic              io_repeat;

    logic              io_in_a_ready;
    logic              io_in_a_valid;
    logic [2:0]        io_in_a_opcode;
    logic [2:0]        io_in_a_param;
    logic [2:0]        io_in_a_size;
    logic [SRC_W-1:0]  io_in_a_source;
    logic [ADDR_W-1:0] io_in_a_address;
    logic              io_in_a_mask;
    logic [7:0]        io_in_a_data;

    logic              io_out_a_ready;
    logic              io_out_a_valid;
    logic [2:0]        io_out_a_opcode;
    logic [2:0]        io_out_a_param;
    logic [2:0]        io_out_a_size;
    logic [SRC_W-1:0]  io_out_a_source;
    logic [ADDR_W-1:0] io_out_a_address;
    logic              io_out_a_mask;
    logic [7:0]        io_out_a_data;

    logic              io_out_d_ready;
    logic              io_out_d_valid;
    logic [2:0]        io_out_d_opcode;
    logic [1:0]        io_out_d_param;
    logic [2:0]        io_out_d_size;
    logic [SRC_W-1:0]  io_out_d_source;
    logic              io_out_d_sink;
    logic [7:0]        io_out_d_data;
    logic              io_out_d_error;

    logic              io_in_d_ready;
    logic              io_in_d_valid;
    logic [2:0]        io_in_d_opcode;
    logic [1:0]        io_in_d_param;
    logic [2:0]        io_in_d_size;
    logic [SRC_W-1:0]  io_in_d_source;
    logic              io_in_d_sink;
    logic [7:0]        io_in_d_data;
    logic              io_in_d_error;

    // Fragmenter side
    modport slave (
        output io_repeat,
        output io_in_a_ready,
        input  io_in_a_valid, io_in_a_opcode, io_in_a_param, io_in_a_size,
               io_in_a_source, io_in_a_address, io_in_a_mask, io_in_a_data,
        input  io_out_a_ready,
        output io_out_a_valid, io_out_a_opcode, io_out_a_param, io_out_a_size,
               io_out_a_source, io_out_a_address, io_out_a_mask, io_out_a_data,
        output io_out_d_ready,
        input  io_out_d_valid, io_out_d_opcode, io_out_d_param, io_out_d_size,
               io_out_d_source, io_out_d_sink, io_out_d_data, io_out_d_error,
        input  io_in_d_ready,
        output io_in_d_valid, io_in_d_opcode, io_in_d_param, io_in_d_size,
               io_in_d_source, io_in_d_sink, io_in_d_data, io_in_d_error
    );

    // Environment side (repeater upstream, peripheral downstream)
    modport master (
        input  io_repeat,
        input  io_in_a_ready,
        output io_in_a_valid, io_in_a_opcode, io_in_a_param, io_in_a_size,
               io_in_a_source, io_in_a_address, io_in_a_mask, io_in_a_data,
        output io_out_a_ready,
        input  io_out_a_valid, io_out_a_opcode, io_out_a_param, io_out_a_size,
               io_out_a_source, io_out_a_address, io_out_a_mask, io_out_a_data,
        input  io_out_d_ready,
        output io_out_d_valid, io_out_d_opcode, io_out_d_param, io_out_d_size,
               io_out_d_source, io_out_d_sink, io_out_d_data, io_out_d_error,
        output io_in_d_ready,
        input  io_in_d_valid, io_in_d_opcode, io_in_d_param, io_in_d_size,
               io_in_d_source, io_in_d_sink, io_in_d_data, io_in_d_error
    );
endinterface
`default_nettype wire

// File: rtl/sirv_frag_counter.sv
`default_nettype none
// ============================================================================
// Module   : sirv_frag_counter
// Brief    : Fragment index counter with clear and last-fragment compare.
// Revision : 1.0
// ============================================================================
module sirv_frag_counter #(
    parameter int MAX_SIZE = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inc,
    input  logic                clear,
    input  logic [MAX_SIZE-1:0] last_idx,
    output logic [MAX_SIZE-1:0] count,
    output logic                last
);
    logic [MAX_SIZE-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + MAX_SIZE'(1);
        end
    end

    assign count = r_cnt;
    assign last  = (r_cnt == last_idx);
endmodule
`default_nettype wire

// File: rtl/sirv_tl_fragmenter_core.sv
`default_nettype none
// ============================================================================
// Module   : sirv_tl_fragmenter_core
// Brief    : TL-UL 1-byte fragmenter: Gets split into single-byte Gets, Put
//            beats forwarded as single-byte Puts, D responses collapsed back.
//            Optional SIRV_FRAG_ERR_ACCUM_EN: sticky error across all D beats.
// Revision : 1.0
// ============================================================================
module sirv_tl_fragmenter_core
    import sirv_tl_pkg::*;
#(
    parameter int MAX_SIZE = 2,
    parameter int ADDR_W   = 30,
    parameter int SRC_W    = 2
) (
    input  logic clock,
    input  logic reset,
    sirv_tl_fragmenter_core_if.slave bus
);
    frag_state_e         r_state;
    frag_state_e         w_next_state;
    logic [2:0]          r_opcode;
    logic [2:0]          r_size;
    logic [SRC_W-1:0]    r_source;
    logic [2:0]          w_size;
    logic [MAX_SIZE-1:0] w_last_idx;
    logic [MAX_SIZE-1:0] w_a_cnt;
    logic [MAX_SIZE-1:0] w_d_cnt;
    logic                w_a_last;
    logic                w_d_last;
    logic                w_a_fire;
    logic                w_d_fire;
    logic                w_not_drain;
    logic                w_d_active;
    logic                w_fwd;
    logic                w_unused_d_size;

    // The current A beat carries the size until it is captured
    assign w_size      = (r_state == IDLE) ? bus.io_in_a_size : r_size;
    assign w_last_idx  = MAX_SIZE'(frag_count(w_size) - 8'd1);
    assign w_not_drain = (r_state != DRAIN);

    // A channel: zero-latency pass-through, closed while draining responses
    assign bus.io_in_a_ready    = bus.io_out_a_ready & w_not_drain;
    assign bus.io_out_a_valid   = bus.io_in_a_valid & w_not_drain;
    assign w_a_fire             = bus.io_in_a_valid & bus.io_in_a_ready;
    assign bus.io_repeat        = bus.io_out_a_valid & (bus.io_in_a_opcode == GET) & ~w_a_last;
    assign bus.io_out_a_opcode  = bus.io_in_a_opcode;
    assign bus.io_out_a_param   = bus.io_in_a_param;
    assign bus.io_out_a_size    = 3'd0;
    assign bus.io_out_a_source  = (r_state == IDLE) ? bus.io_in_a_source : r_source;
    assign bus.io_out_a_mask    = bus.io_in_a_mask;
    assign bus.io_out_a_data    = bus.io_in_a_data;
    assign bus.io_out_a_address = {bus.io_in_a_address[ADDR_W-1:MAX_SIZE],
                                   bus.io_in_a_address[MAX_SIZE-1:0] | (w_a_cnt & w_last_idx)};

    sirv_frag_counter #(.MAX_SIZE(MAX_SIZE)) u_a_cnt (
        .clock    (clock),
        .reset    (reset),
        .inc      (w_a_fire & ~w_a_last),
        .clear    (w_a_fire & w_a_last),
        .last_idx (w_last_idx),
        .count    (w_a_cnt),
        .last     (w_a_last)
    );

    // D channel: Get data always forwarded, Put acks swallowed until the last
    assign w_d_active         = (r_state != IDLE);
    assign w_fwd              = (r_opcode == GET) | w_d_last;
    assign bus.io_in_d_valid  = bus.io_out_d_valid & w_d_active & w_fwd;
    assign bus.io_out_d_ready = w_d_active & (~w_fwd | bus.io_in_d_ready);
    assign w_d_fire           = bus.io_out_d_valid & bus.io_out_d_ready;
    assign bus.io_in_d_opcode = bus.io_out_d_opcode;
    assign bus.io_in_d_param  = bus.io_out_d_param;
    assign bus.io_in_d_size   = r_size;
    assign bus.io_in_d_source = bus.io_out_d_source;
    assign bus.io_in_d_sink   = bus.io_out_d_sink;
    assign bus.io_in_d_data   = bus.io_out_d_data;
    assign w_unused_d_size    = ^bus.io_out_d_size;

    sirv_frag_counter #(.MAX_SIZE(MAX_SIZE)) u_d_cnt (
        .clock    (clock),
        .reset    (reset),
        .inc      (w_d_fire & ~w_d_last),
        .clear    (w_d_fire & w_d_last),
        .last_idx (w_last_idx),
        .count    (w_d_cnt),
        .last     (w_d_last)
    );

`ifdef SIRV_FRAG_ERR_ACCUM_EN
    logic r_err_acc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_acc <= 1'b0;
        end else if (w_d_fire) begin
            r_err_acc <= w_d_last ? 1'b0 : (r_err_acc | bus.io_out_d_error);
        end
    end

    assign bus.io_in_d_error = bus.io_out_d_error | r_err_acc;
`else
    assign bus.io_in_d_error = bus.io_out_d_error;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_opcode <= '0;
            r_size   <= '0;
            r_source <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && w_a_fire) begin
                r_opcode <= bus.io_in_a_opcode;
                r_size   <= bus.io_in_a_size;
                r_source <= bus.io_in_a_source;
            end
        end
    end

    // The last response closes the transaction even if it races the last A
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_a_fire) begin
                    w_next_state = w_a_last ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (w_d_fire && w_d_last) begin
                    w_next_state = IDLE;
                end else if (w_a_fire && w_a_last) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_d_fire && w_d_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_sirv_tl_fragmenter_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sirv_tl_fragmenter_core
// Brief    : Directed scoreboard bench for the TL-UL fragmenter core.
// Revision : 1.0
// ============================================================================
module tb_sirv_tl_fragmenter_core;
    import sirv_tl_pkg::*;

    localparam int MAX_SIZE = 2;
    localparam int ADDR_W   = 30;
    localparam int SRC_W    = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sirv_tl_fragmenter_core_if #(.ADDR_W(ADDR_W), .SRC_W(SRC_W)) bus ();

    sirv_tl_fragmenter_core #(.MAX_SIZE(MAX_SIZE), .ADDR_W(ADDR_W), .SRC_W(SRC_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]        opcode;
        logic [2:0]        size;
        logic [SRC_W-1:0]  source;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } a_beat_t;

    typedef struct {
        logic [2:0]        opcode;
        logic [SRC_W-1:0]  source;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              rpt;
    } exp_a_t;

    typedef struct {
        logic [2:0]       opcode;
        logic [2:0]       size;
        logic [SRC_W-1:0] source;
        logic [7:0]       data;
        logic             error;
        int               due;
    } d_beat_t;

    a_beat_t up_q[$];
    exp_a_t  exp_a_q[$];
    d_beat_t exp_d_q[$];
    d_beat_t pend_q[$];
    bit      err_q[$];
    bit      ardy_q[$];
    bit      drdy_q[$];

    int n_assert   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int resp_delay = 1;
    int a_frags    = 0;

    logic              hold_a = 1'b0;
    logic              hold_d = 1'b0;
    logic [ADDR_W-1:0] hold_addr;
    logic [7:0]        hold_adata;
    logic [7:0]        hold_ddata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sizes above MAX_SIZE must never reach the core
    always @(negedge clock) begin
        if (!reset && bus.io_in_a_valid) begin
            chk("size_legal", 32'(bus.io_in_a_size <= 3'(MAX_SIZE)), 32'd1);
        end
    end

    task automatic drive();
        if (up_q.size() > 0) begin
            bus.io_in_a_valid   = 1'b1;
            bus.io_in_a_opcode  = up_q[0].opcode;
            bus.io_in_a_size    = up_q[0].size;
            bus.io_in_a_source  = up_q[0].source;
            bus.io_in_a_address = up_q[0].addr;
            bus.io_in_a_data    = up_q[0].data;
        end else begin
            bus.io_in_a_valid   = 1'b0;
        end
        bus.io_out_a_ready = (ardy_q.size() > 0) ? ardy_q.pop_front() : 1'b1;
        bus.io_in_d_ready  = (drdy_q.size() > 0) ? drdy_q.pop_front() : 1'b1;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus.io_out_d_valid  = 1'b1;
            bus.io_out_d_opcode = pend_q[0].opcode;
            bus.io_out_d_source = pend_q[0].source;
            bus.io_out_d_data   = pend_q[0].data;
            bus.io_out_d_error  = pend_q[0].error;
        end else begin
            bus.io_out_d_valid  = 1'b0;
        end
    endtask

    // One clock: check at negedge, then advance the upstream/downstream models
    task automatic step();
        logic              a_fire;
        logic              rpt;
        logic              od_fire;
        logic              id_fire;
        logic              in_drain;
        logic [ADDR_W-1:0] oaddr;
        logic [2:0]        oop;
        logic [SRC_W-1:0]  osrc;
        exp_a_t            ea;
        d_beat_t           ed;
        d_beat_t           rsp;
        @(negedge clock);
        a_fire   = bus.io_out_a_valid & bus.io_out_a_ready;
        rpt      = bus.io_repeat;
        od_fire  = bus.io_out_d_valid & bus.io_out_d_ready;
        id_fire  = bus.io_in_d_valid & bus.io_in_d_ready;
        oaddr    = bus.io_out_a_address;
        oop      = bus.io_out_a_opcode;
        osrc     = bus.io_out_a_source;
        in_drain = (exp_a_q.size() == 0) && (exp_d_q.size() > 0);

        if (hold_a) begin
            chk("a_hold_valid", 32'(bus.io_out_a_valid), 32'd1);
            chk("a_hold_addr", 32'(bus.io_out_a_address), 32'(hold_addr));
            chk("a_hold_data", 32'(bus.io_out_a_data), 32'(hold_adata));
        end
        hold_a     = bus.io_out_a_valid & ~bus.io_out_a_ready;
        hold_addr  = bus.io_out_a_address;
        hold_adata = bus.io_out_a_data;
        if (hold_d) begin
            chk("d_hold_valid", 32'(bus.io_in_d_valid), 32'd1);
            chk("d_hold_data", 32'(bus.io_in_d_data), 32'(hold_ddata));
        end
        hold_d     = bus.io_in_d_valid & ~bus.io_in_d_ready;
        hold_ddata = bus.io_in_d_data;

        if (in_drain) begin
            chk("drain_in_a_ready", 32'(bus.io_in_a_ready), 32'd0);
        end
        if (a_fire) begin
            chk("a_expected", 32'(exp_a_q.size() > 0), 32'd1);
            if (exp_a_q.size() > 0) begin
                ea = exp_a_q.pop_front();
                chk("a_addr", 32'(bus.io_out_a_address), 32'(ea.addr));
                chk("a_data", 32'(bus.io_out_a_data), 32'(ea.data));
                chk("a_opcode", 32'(bus.io_out_a_opcode), 32'(ea.opcode));
                chk("a_source", 32'(bus.io_out_a_source), 32'(ea.source));
                chk("a_size", 32'(bus.io_out_a_size), 32'd0);
                chk("a_repeat", 32'(rpt), 32'(ea.rpt));
            end
        end
        if (id_fire) begin
            chk("d_expected", 32'(exp_d_q.size() > 0), 32'd1);
            if (exp_d_q.size() > 0) begin
                ed = exp_d_q.pop_front();
                chk("d_opcode", 32'(bus.io_in_d_opcode), 32'(ed.opcode));
                chk("d_size", 32'(bus.io_in_d_size), 32'(ed.size));
                chk("d_source", 32'(bus.io_in_d_source), 32'(ed.source));
                chk("d_data", 32'(bus.io_in_d_data), 32'(ed.data));
                chk("d_error", 32'(bus.io_in_d_error), 32'(ed.error));
            end
        end

        @(posedge clock);
        #1;
        cyc++;
        if (a_fire) begin
            a_frags++;
            if (!rpt && up_q.size() > 0) void'(up_q.pop_front());
            rsp.opcode = (oop == GET) ? ACCESSACKDATA : ACCESSACK;
            rsp.size   = 3'd0;
            rsp.source = osrc;
            rsp.data   = (oop == GET) ? (oaddr[7:0] ^ 8'h3C) : 8'h00;
            rsp.error  = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
            rsp.due    = cyc + resp_delay - 1;
            pend_q.push_back(rsp);
        end
        if (od_fire && pend_q.size() > 0) void'(pend_q.pop_front());
        drive();
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [SRC_W-1:0] src,
                        input logic [ADDR_W-1:0] addr, input logic [7:0] d0, input logic [7:0] err_mask);
        int      n = 1 << size;
        logic    acc = 1'b0;
        logic    e;
        a_beat_t b;
        exp_a_t  ea;
        d_beat_t ed;
        for (int i = 0; i < n; i++) begin
            b.opcode = op;
            b.size   = size;
            b.source = src;
            b.addr   = addr;
            b.data   = (op == GET) ? d0 : d0 + 8'(i * 17);
            if (op != GET || i == 0) up_q.push_back(b);
            ea.opcode = op;
            ea.source = src;
            ea.addr   = addr | ADDR_W'(i);
            ea.data   = b.data;
            ea.rpt    = (op == GET) && (i != n - 1);
            exp_a_q.push_back(ea);
            err_q.push_back(err_mask[i]);
            acc = acc | err_mask[i];
`ifdef SIRV_FRAG_ERR_ACCUM_EN
            e = acc;
`else
            e = err_mask[i];
`endif
            ed.size   = size;
            ed.source = src;
            ed.error  = e;
            ed.due    = 0;
            if (op == GET) begin
                ed.opcode = ACCESSACKDATA;
                ed.data   = ea.addr[7:0] ^ 8'h3C;
                exp_d_q.push_back(ed);
            end else if (i == n - 1) begin
                ed.opcode = ACCESSACK;
                ed.data   = 8'h00;
                exp_d_q.push_back(ed);
            end
        end
    endtask

    task automatic run_done(input int bound);
        int k = 0;
        drive();
        while ((up_q.size() > 0 || exp_a_q.size() > 0 || exp_d_q.size() > 0 || pend_q.size() > 0)
               && k < bound) begin
            step();
            k++;
        end
        chk("txn_timeout", 32'(k < bound), 32'd1);
        chk("txn_end_idle", 32'(dut.r_state), 32'(IDLE));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        up_q.delete();
        exp_a_q.delete();
        exp_d_q.delete();
        pend_q.delete();
        err_q.delete();
        ardy_q.delete();
        drdy_q.delete();
        hold_a = 1'b0;
        hold_d = 1'b0;
        bus.io_in_a_valid  = 1'b0;
        bus.io_out_d_valid = 1'b0;
        bus.io_out_a_ready = 1'b0;
        bus.io_in_d_ready  = 1'b1;
        @(negedge clock);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        chk("rst_a_cnt", 32'(dut.u_a_cnt.r_cnt), 32'd0);
        chk("rst_d_cnt", 32'(dut.u_d_cnt.r_cnt), 32'd0);
        chk("rst_in_a_ready", 32'(bus.io_in_a_ready), 32'd0);
        chk("rst_out_a_valid", 32'(bus.io_out_a_valid), 32'd0);
        chk("rst_in_d_valid", 32'(bus.io_in_d_valid), 32'd0);
        chk("rst_repeat", 32'(bus.io_repeat), 32'd0);
        chk("rst_out_d_ready", 32'(bus.io_out_d_ready), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc++;
        drive();
    endtask

    initial begin
        int k;
        bus.io_in_a_valid   = 1'b0;
        bus.io_in_a_opcode  = 3'd0;
        bus.io_in_a_param   = 3'd0;
        bus.io_in_a_size    = 3'd0;
        bus.io_in_a_source  = '0;
        bus.io_in_a_address = '0;
        bus.io_in_a_mask    = 1'b1;
        bus.io_in_a_data    = 8'h00;
        bus.io_out_a_ready  = 1'b0;
        bus.io_out_d_valid  = 1'b0;
        bus.io_out_d_opcode = 3'd0;
        bus.io_out_d_param  = 2'd0;
        bus.io_out_d_size   = 3'd0;
        bus.io_out_d_source = '0;
        bus.io_out_d_sink   = 1'b0;
        bus.io_out_d_data   = 8'h00;
        bus.io_out_d_error  = 1'b0;
        bus.io_in_d_ready   = 1'b0;

        do_reset();

        // 4-byte Get split into four single-byte Gets
        send(GET, 3'd2, 2'd1, 30'h100, 8'h00, 8'h00);
        run_done(60);

        // 2-beat PutFull, first ack swallowed
        send(PUTFULL, 3'd1, 2'd2, 30'h22, 8'hAA, 8'h00);
        run_done(60);

        // Single-fragment Get with slow response, A held closed while draining
        resp_delay = 3;
        send(GET, 3'd0, 2'd3, 30'h7, 8'h00, 8'h00);
        run_done(60);
        resp_delay = 1;

        // Backpressure on both downstream A and upstream D
        send(GET, 3'd1, 2'd0, 30'h58, 8'h00, 8'h00);
        ardy_q = '{1'b1, 1'b0, 1'b1};
        drdy_q = '{1'b0, 1'b0, 1'b0};
        run_done(60);

        // Error on a dropped Put ack
        send(PUTFULL, 3'd1, 2'd1, 30'h30, 8'h11, 8'h01);
        run_done(60);

        // 4-beat PutFull with an error on the last ack
        resp_delay = 2;
        send(PUTFULL, 3'd2, 2'd2, 30'h44, 8'h20, 8'h08);
        run_done(60);

        // Reset in the middle of a 4-fragment Get
        a_frags = 0;
        send(GET, 3'd2, 2'd1, 30'h40, 8'h00, 8'h00);
        drive();
        k = 0;
        while (a_frags < 2 && k < 40) begin
            step();
            k++;
        end
        chk("reset_setup_timeout", 32'(k < 40), 32'd1);
        chk("pre_reset_state", 32'(dut.r_state), 32'(ISSUE));
        do_reset();
        resp_delay = 1;
        send(GET, 3'd0, 2'd2, 30'h9, 8'h00, 8'h00);
        run_done(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
